// File: rtl/ysyx_23060229_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter with alternating tie priority
// and a response timeout that reports an error instead of stalling the core.
module ysyx_23060229_mem_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [31:0] ifu_addr,
   output logic        ifu_resp_valid,
   output logic        ifu_resp_err,
   output logic [31:0] ifu_rdata,
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic [31:0] lsu_addr,
   input  logic        lsu_wen,
   input  logic [31:0] lsu_wdata,
   input  logic [7:0]  lsu_wmask,
   output logic        lsu_resp_valid,
   output logic        lsu_resp_err,
   output logic [31:0] lsu_rdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   localparam logic             OWN_IFU  = 1'b0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state, next_state;
   logic             owner, last_grant;
   logic [CNT_W-1:0] counter;
   logic [31:0]      addr_q, wdata_q;
   logic             wen_q;
   logic [7:0]       wmask_q;
   logic             grant_ifu, grant_lsu;
   logic             resp_done, timed_out;

   // On a tie the master that lost the previous grant wins.
   always_comb begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      if (state == IDLE && !rst) begin
         if (ifu_req_valid && lsu_req_valid) begin
            grant_lsu = (last_grant == OWN_IFU);
            grant_ifu = !grant_lsu;
         end else begin
            grant_ifu = ifu_req_valid;
            grant_lsu = lsu_req_valid;
         end
      end
   end

   // A real response in the expiry cycle takes precedence over the timeout.
   assign timed_out = (state == RESP) && !mem_resp_valid && (counter == CNT_LAST);
   assign resp_done = (state == RESP) && (mem_resp_valid || counter == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (grant_ifu || grant_lsu) next_state = REQ;
         REQ:     if (mem_req_ready)          next_state = RESP;
         RESP:    if (resp_done)              next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request fields are captured at grant so masters may drop valid afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner      <= OWN_IFU;
         last_grant <= OWN_IFU;
         counter    <= '0;
         addr_q     <= '0;
         wen_q      <= 1'b0;
         wdata_q    <= '0;
         wmask_q    <= '0;
      end else begin
         if (grant_ifu || grant_lsu) begin
            owner      <= grant_lsu;
            last_grant <= grant_lsu;
            addr_q     <= grant_lsu ? lsu_addr : ifu_addr;
            wen_q      <= grant_lsu & lsu_wen;
            wdata_q    <= grant_lsu ? lsu_wdata : 32'h0;
            wmask_q    <= grant_lsu ? lsu_wmask : 8'h0;
         end
         if (state == REQ && mem_req_ready) begin
            counter <= '0;
         end else if (state == RESP && !resp_done) begin
            counter <= counter + 1'b1;
         end
      end
   end

   always_comb begin
      ifu_req_ready  = grant_ifu;
      lsu_req_ready  = grant_lsu;
      mem_req_valid  = 1'b0;
      mem_addr       = '0;
      mem_wen        = 1'b0;
      mem_wdata      = '0;
      mem_wmask      = '0;
      ifu_resp_valid = 1'b0;
      ifu_resp_err   = 1'b0;
      ifu_rdata      = '0;
      lsu_resp_valid = 1'b0;
      lsu_resp_err   = 1'b0;
      lsu_rdata      = '0;
      if (!rst) begin
         mem_req_valid = (state == REQ);
         mem_addr      = addr_q;
         mem_wen       = wen_q;
         mem_wdata     = wdata_q;
         mem_wmask     = wmask_q;
         if (resp_done) begin
            if (owner == OWN_IFU) begin
               ifu_resp_valid = 1'b1;
               ifu_resp_err   = timed_out;
               ifu_rdata      = timed_out ? 32'h0 : mem_rdata;
            end else begin
               lsu_resp_valid = 1'b1;
               lsu_resp_err   = timed_out;
               lsu_rdata      = timed_out ? 32'h0 : mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060229_mem_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model of the arbiter.
module tb_ysyx_23060229_mem_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [7:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;

   int checks = 0;
   int errors = 0;

   // Transaction-level model state
   bit          m_busy, m_sent, m_owner, m_last, m_gnt_ifu, m_gnt_lsu;
   int          m_wait;
   logic [31:0] m_addr, m_wdata;
   logic        m_wen;
   logic [7:0]  m_wmask;

   ysyx_23060229_mem_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_err(ifu_resp_err), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_err(lsu_resp_err), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic iv, input logic [31:0] ia,
                                input logic lv, input logic [31:0] la, input logic lw,
                                input logic [31:0] lwd, input logic [7:0] lm,
                                input logic mrr, input logic mrv, input logic [31:0] mrd);
      @(posedge clk); #1;
      rst = r; ifu_req_valid = iv; ifu_addr = ia;
      lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lm;
      mem_req_ready = mrr; mem_resp_valid = mrv; mem_rdata = mrd;
   endtask

   task automatic waitSample;
      @(negedge clk); #1;
   endtask

   // Per-cycle compare against the model; the model then advances one cycle.
   initial begin
      logic        e_irdy, e_lrdy, e_mreq, e_iv, e_ie, e_lv, e_le, win_lsu;
      logic [31:0] e_ird, e_lrd, e_addr, e_wd;
      logic        e_wen;
      logic [7:0]  e_wm;
      forever begin
         @(negedge clk);
         {e_irdy, e_lrdy, e_mreq, e_iv, e_ie, e_lv, e_le} = '0;
         e_ird = '0; e_lrd = '0; e_addr = '0; e_wd = '0; e_wen = 1'b0; e_wm = '0;
         m_gnt_ifu = 1'b0; m_gnt_lsu = 1'b0;
         if (rst) begin
            m_busy = 1'b0; m_sent = 1'b0; m_last = 1'b0; m_owner = 1'b0;
         end else if (!m_busy) begin
            win_lsu = (ifu_req_valid && lsu_req_valid) ? !m_last : lsu_req_valid;
            if (ifu_req_valid || lsu_req_valid) begin
               e_irdy = !win_lsu; e_lrdy = win_lsu;
               m_gnt_ifu = !win_lsu; m_gnt_lsu = win_lsu;
               m_busy = 1'b1; m_sent = 1'b0; m_owner = win_lsu; m_last = win_lsu;
               m_addr  = win_lsu ? lsu_addr : ifu_addr;
               m_wen   = win_lsu ? lsu_wen : 1'b0;
               m_wdata = win_lsu ? lsu_wdata : 32'h0;
               m_wmask = win_lsu ? lsu_wmask : 8'h0;
            end
         end else if (!m_sent) begin
            e_mreq = 1'b1; e_addr = m_addr; e_wen = m_wen; e_wd = m_wdata; e_wm = m_wmask;
            if (mem_req_ready) begin m_sent = 1'b1; m_wait = 0; end
         end else if (mem_resp_valid || m_wait + 1 == TO) begin
            if (m_owner) begin
               e_lv = 1'b1; e_le = !mem_resp_valid; e_lrd = mem_resp_valid ? mem_rdata : 32'h0;
            end else begin
               e_iv = 1'b1; e_ie = !mem_resp_valid; e_ird = mem_resp_valid ? mem_rdata : 32'h0;
            end
            m_busy = 1'b0;
         end else begin
            m_wait++;
         end
         checkOutput("ifu_req_ready", 32'(ifu_req_ready), 32'(e_irdy));
         checkOutput("lsu_req_ready", 32'(lsu_req_ready), 32'(e_lrdy));
         checkOutput("mem_req_valid", 32'(mem_req_valid), 32'(e_mreq));
         checkOutput("ifu_resp_valid", 32'(ifu_resp_valid), 32'(e_iv));
         checkOutput("ifu_resp_err", 32'(ifu_resp_err), 32'(e_ie));
         checkOutput("ifu_rdata", ifu_rdata, e_ird);
         checkOutput("lsu_resp_valid", 32'(lsu_resp_valid), 32'(e_lv));
         checkOutput("lsu_resp_err", 32'(lsu_resp_err), 32'(e_le));
         checkOutput("lsu_rdata", lsu_rdata, e_lrd);
         if (rst || e_mreq) begin
            checkOutput("mem_addr", mem_addr, e_addr);
            checkOutput("mem_wen", 32'(mem_wen), 32'(e_wen));
            checkOutput("mem_wdata", mem_wdata, e_wd);
            checkOutput("mem_wmask", 32'(mem_wmask), 32'(e_wm));
         end
      end
   end

   initial begin
      rst = 1'b1; ifu_req_valid = 0; ifu_addr = 0; lsu_req_valid = 0; lsu_addr = 0;
      lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; mem_req_ready = 0; mem_resp_valid = 0;
      mem_rdata = 0;
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      waitSample;
      checkOutput("reset mem_req_valid", 32'(mem_req_valid), 0);

      // IFU-only fetch with a ready memory
      applyStimulus(0, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 1, 0, 0);
      waitSample;
      checkOutput("t1 ifu_req_ready", 32'(ifu_req_ready), 1);
      checkOutput("t1 lsu_req_ready", 32'(lsu_req_ready), 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      waitSample;
      checkOutput("t1 mem_req_valid", 32'(mem_req_valid), 1);
      checkOutput("t1 mem_addr", mem_addr, 32'h8000_0000);
      checkOutput("t1 mem_wen", 32'(mem_wen), 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0413);
      waitSample;
      checkOutput("t1 ifu_resp_valid", 32'(ifu_resp_valid), 1);
      checkOutput("t1 ifu_rdata", ifu_rdata, 32'h0000_0413);
      checkOutput("t1 lsu_resp_valid", 32'(lsu_resp_valid), 0);

      // LSU store with memory stalling the request for three cycles
      applyStimulus(0, 0, 0, 1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 8'h0F, 0, 0, 0);
      waitSample;
      checkOutput("t2 lsu_req_ready", 32'(lsu_req_ready), 1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, (i == 3), 0, 0);
         waitSample;
         checkOutput("t2 mem_req_valid", 32'(mem_req_valid), 1);
         checkOutput("t2 mem_addr", mem_addr, 32'h8000_1000);
         checkOutput("t2 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
         checkOutput("t2 mem_wmask", 32'(mem_wmask), 32'h0F);
         checkOutput("t2 mem_wen", 32'(mem_wen), 1);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
      waitSample;
      checkOutput("t2 lsu_resp_valid", 32'(lsu_resp_valid), 1);
      checkOutput("t2 lsu_resp_err", 32'(lsu_resp_err), 0);

      // Ties after reset alternate LSU, IFU, LSU
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 0, 0);
         waitSample;
         checkOutput("t3 lsu_req_ready", 32'(lsu_req_ready), 32'(k != 1));
         checkOutput("t3 ifu_req_ready", 32'(ifu_req_ready), 32'(k == 1));
         applyStimulus(0, 1, 32'h100, 1, 32'h200, 0, 0, 0, 1, 0, 0);
         applyStimulus(0, 1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 1, 32'h77);
      end

      // Timeout, late response ignored, then a normal transaction
      applyStimulus(0, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234);
      end
      waitSample;
      checkOutput("t4 ifu_resp_valid", 32'(ifu_resp_valid), 1);
      checkOutput("t4 ifu_resp_err", 32'(ifu_resp_err), 1);
      checkOutput("t4 ifu_rdata", ifu_rdata, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h9999);
      waitSample;
      checkOutput("t4 late ifu_resp_valid", 32'(ifu_resp_valid), 0);
      checkOutput("t4 late lsu_resp_valid", 32'(lsu_resp_valid), 0);
      applyStimulus(0, 1, 32'h304, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
      waitSample;
      checkOutput("t4 next ifu_rdata", ifu_rdata, 32'h55);
      checkOutput("t4 next ifu_resp_err", 32'(ifu_resp_err), 0);

      // Response arriving in the expiry cycle wins over the timeout
      applyStimulus(0, 0, 0, 1, 32'h400, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
      waitSample;
      checkOutput("t5 lsu_resp_valid", 32'(lsu_resp_valid), 1);
      checkOutput("t5 lsu_resp_err", 32'(lsu_resp_err), 0);
      checkOutput("t5 lsu_rdata", lsu_rdata, 32'hCAFE_F00D);

      // Reset while waiting for a response drops the transaction
      applyStimulus(0, 1, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA);
      waitSample;
      checkOutput("t6 rst ifu_resp_valid", 32'(ifu_resp_valid), 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBBBB);
      waitSample;
      checkOutput("t6 post mem_req_valid", 32'(mem_req_valid), 0);
      checkOutput("t6 post ifu_resp_valid", 32'(ifu_resp_valid), 0);
      applyStimulus(0, 1, 32'h504, 0, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h66);
      waitSample;
      checkOutput("t6 ifu_rdata", ifu_rdata, 32'h66);

      // Random traffic; masters hold valid until granted, with occasional drops
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk); #1;
         if (!ifu_req_valid || m_gnt_ifu || $urandom_range(19) == 0) begin
            ifu_req_valid = ($urandom_range(9) < 4);
            ifu_addr      = $urandom;
         end
         if (!lsu_req_valid || m_gnt_lsu || $urandom_range(19) == 0) begin
            lsu_req_valid = ($urandom_range(9) < 4);
            lsu_addr      = $urandom;
            lsu_wen       = 1'($urandom_range(1));
            lsu_wdata     = $urandom;
            lsu_wmask     = 8'($urandom_range(255));
         end
         mem_req_ready  = 1'($urandom_range(1));
         mem_resp_valid = ($urandom_range(3) == 0);
         mem_rdata      = $urandom;
         rst            = ($urandom_range(99) == 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      waitSample;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
